// File: rtl/tenkey_debounce.sv
// Ten-key keypad front end: synchronizes raw switches, debounces a single
// pressed digit and emits one registered one-hot pulse per accepted press.
module tenkey_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sw_raw,
  output logic [9:0] tenkey,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       multi_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, RELEASE} state_t;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [9:0] cand, cand_n;
  logic [9:0] sync_meta, sync;
  logic [9:0] tenkey_n;
  logic       multi_err_n;
  logic       one_hot, multi_hot;

  function automatic logic [3:0] encode(input logic [9:0] v);
    encode = 4'hF;
    for (int i = 0; i < 10; i++)
      if (v[i]) encode = 4'(i);
  endfunction

  always_comb begin
    one_hot   = (sync != '0) && ((sync & (sync - 10'd1)) == '0);
    multi_hot = (sync != '0) && !one_hot;
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cand_n      = cand;
    tenkey_n    = '0;
    multi_err_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (one_hot) begin
          cand_n  = sync;
          cnt_n   = 8'd1;
          state_n = DEBOUNCE;
        end else if (multi_hot) begin
          multi_err_n = 1'b1;
          cnt_n       = '0;
          state_n     = RELEASE;
        end
      end
      DEBOUNCE: begin
        if (sync == cand) begin
          if (cnt == LAST) begin
            tenkey_n = cand;
            cnt_n    = '0;
            state_n  = RELEASE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else if (sync == '0) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (one_hot) begin
          cand_n = sync;
          cnt_n  = 8'd1;
        end else begin
          multi_err_n = 1'b1;
          cnt_n       = '0;
          state_n     = RELEASE;
        end
      end
      RELEASE: begin
        // Leave only after DEBOUNCE_CYCLES consecutive all-released samples.
        if (sync != '0) begin
          cnt_n = '0;
        end else if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      sync_meta <= '0;
      sync      <= '0;
      tenkey    <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'hF;
      multi_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      sync_meta <= sw_raw;
      sync      <= sync_meta;
      tenkey    <= tenkey_n;
      key_valid <= |tenkey_n;
      key_code  <= encode(tenkey_n);
      multi_err <= multi_err_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tenkey_debounce.sv
// Self-checking bench for tenkey_debounce (DEBOUNCE_CYCLES=4) against a
// run-length reference model of the keypad acceptance rules.
module tb_tenkey_debounce;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [9:0] sw_raw;
  logic [9:0] tenkey;
  logic       key_valid;
  logic [3:0] key_code;
  logic       multi_err;
  logic       busy;

  tenkey_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .tenkey    (tenkey),
    .key_valid (key_valid),
    .key_code  (key_code),
    .multi_err (multi_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a press is accepted after N identical one-hot samples
  // while armed; after any acceptance or multi-key event it must see N
  // consecutive all-released samples before arming again.
  logic [9:0] m_s1, m_s2;
  bit         m_armed;
  int         m_run_len, m_zero_run;
  logic [9:0] m_run_val;
  logic [9:0] m_tk;
  bit         m_me;

  wire [16:0] obs = {tenkey, key_valid, key_code, multi_err, busy};

  function automatic bit is_one_hot(input logic [9:0] v);
    int c = 0;
    for (int i = 0; i < 10; i++) c += int'(v[i]);
    return c == 1;
  endfunction

  function automatic logic [3:0] digit(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return 4'(i);
    return 4'hF;
  endfunction

  function automatic logic [16:0] m_vec();
    bit b = !m_armed || (m_run_len != 0);
    return {m_tk, (m_tk != 0), digit(m_tk), m_me, b};
  endfunction

  task automatic model_edge(input logic r, input logic [9:0] sw);
    logic [9:0] s;
    m_tk = '0;
    m_me = 1'b0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_armed = 1; m_run_len = 0; m_zero_run = 0; m_run_val = '0;
      return;
    end
    s = m_s2; m_s2 = m_s1; m_s1 = sw;
    if (m_armed) begin
      if (s == 0) m_run_len = 0;
      else if (is_one_hot(s)) begin
        if (m_run_len > 0 && s == m_run_val) m_run_len++;
        else begin m_run_val = s; m_run_len = 1; end
        if (m_run_len == N) begin
          m_tk = m_run_val; m_armed = 0; m_run_len = 0; m_zero_run = 0;
        end
      end else begin
        m_me = 1'b1; m_armed = 0; m_run_len = 0; m_zero_run = 0;
      end
    end else begin
      if (s == 0) begin
        m_zero_run++;
        if (m_zero_run == N) m_armed = 1;
      end else m_zero_run = 0;
    end
  endtask

  task automatic step(input logic r, input logic [9:0] sw);
    rst    = r;
    sw_raw = sw;
    @(posedge clk);
    model_edge(r, sw);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 10'h3FF);
    step(1'b1, 10'h3FF);
    n_checks++; if (tenkey !== 10'h000) $display("FAIL reset_tenkey got %h want 000", tenkey); else n_pass++;
    n_checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid got %b want 0", key_valid); else n_pass++;
    n_checks++; if (key_code !== 4'hF) $display("FAIL reset_key_code got %h want F", key_code); else n_pass++;
    n_checks++; if (multi_err !== 1'b0) $display("FAIL reset_multi_err got %b want 0", multi_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b0, 10'h000);
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int pulse_at = -1;
    int idle_at = -1;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, (i < 12) ? 10'h080 : 10'h000);
      n_checks++; if (obs !== m_vec()) $display("FAIL clean_model cyc %0d got %h want %h", i, obs, m_vec()); else n_pass++;
      if (tenkey != 0) begin
        pulses++; pulse_at = i;
        n_checks++; if (key_code !== 4'd7 || tenkey !== 10'h080 || key_valid !== 1'b1)
          $display("FAIL clean_code got tk=%h kc=%h kv=%b want 080/7/1", tenkey, key_code, key_valid); else n_pass++;
      end
      if (i >= 12 && !busy && idle_at < 0) idle_at = i;
    end
    n_checks++; if (pulses !== 1) $display("FAIL clean_pulse_count got %0d want 1", pulses); else n_pass++;
    n_checks++; if (pulse_at !== N + 1) $display("FAIL clean_latency got edge %0d want %0d", pulse_at, N + 1); else n_pass++;
    n_checks++; if (idle_at !== 17) $display("FAIL clean_release_idle got edge %0d want 17", idle_at); else n_pass++;
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int pulse_at = -1;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, (i == 2) ? 10'h000 : (i < 13) ? 10'h080 : 10'h000);
      n_checks++; if (obs !== m_vec()) $display("FAIL bounce_model cyc %0d got %h want %h", i, obs, m_vec()); else n_pass++;
      if (tenkey != 0) begin pulses++; pulse_at = i; end
    end
    n_checks++; if (pulses !== 1) $display("FAIL bounce_pulse_count got %0d want 1", pulses); else n_pass++;
    n_checks++; if (pulse_at !== 3 + N + 1) $display("FAIL bounce_latency got edge %0d want %0d", pulse_at, 3 + N + 1); else n_pass++;
  endtask

  task automatic test_multi_key();
    int errs = 0;
    int pulses = 0;
    logic [9:0] sw;
    logic [3:0] code = 4'hF;
    for (int i = 0; i < 36; i++) begin
      sw = (i < 3) ? 10'h081 : (i < 11) ? 10'h001 : (i < 17) ? 10'h000 : (i < 26) ? 10'h001 : 10'h000;
      step(1'b0, sw);
      n_checks++; if (obs !== m_vec()) $display("FAIL multi_model cyc %0d got %h want %h", i, obs, m_vec()); else n_pass++;
      if (multi_err) errs++;
      if (tenkey != 0) begin
        pulses++; code = key_code;
        n_checks++; if (i !== 17 + N + 1) $display("FAIL multi_accept_edge got %0d want %0d", i, 17 + N + 1); else n_pass++;
      end
      n_checks++; if (multi_err && tenkey != 0) $display("FAIL multi_overlap cyc %0d got both high want exclusive", i); else n_pass++;
    end
    n_checks++; if (errs !== 1) $display("FAIL multi_err_count got %0d want 1", errs); else n_pass++;
    n_checks++; if (pulses !== 1 || code !== 4'd0) $display("FAIL multi_after_release got %0d pulses code %h want 1 pulse code 0", pulses, code); else n_pass++;
  endtask

  task automatic test_key_roll();
    int pulses = 0;
    logic [9:0] sw;
    logic [9:0] seen [$];
    for (int i = 0; i < 40; i++) begin
      sw = (i < 8) ? 10'h080 : (i < 16) ? 10'h100 : (i < 24) ? 10'h000 : (i < 32) ? 10'h100 : 10'h000;
      step(1'b0, sw);
      n_checks++; if (obs !== m_vec()) $display("FAIL roll_model cyc %0d got %h want %h", i, obs, m_vec()); else n_pass++;
      if (tenkey != 0) begin pulses++; seen.push_back(tenkey); end
    end
    n_checks++; if (pulses !== 2) $display("FAIL roll_pulse_count got %0d want 2", pulses); else n_pass++;
    if (pulses == 2) begin
      n_checks++; if (seen[0] !== 10'h080 || seen[1] !== 10'h100)
        $display("FAIL roll_order got %h,%h want 080,100", seen[0], seen[1]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    int pulses = 0;
    int pulse_at = -1;
    for (int i = 0; i < 20; i++) begin
      step(i == 4, (i < 14) ? 10'h200 : 10'h000);
      n_checks++; if (obs !== m_vec()) $display("FAIL rstmid_model cyc %0d got %h want %h", i, obs, m_vec()); else n_pass++;
      if (tenkey != 0) begin
        pulses++; pulse_at = i;
        n_checks++; if (key_code !== 4'd9) $display("FAIL rstmid_code got %h want 9", key_code); else n_pass++;
      end
    end
    n_checks++; if (pulses !== 1 || pulse_at !== 5 + N + 1)
      $display("FAIL rstmid_pulse got %0d at %0d want 1 at %0d", pulses, pulse_at, 5 + N + 1); else n_pass++;
    for (int i = 0; i < 8; i++) step(1'b0, 10'h000);
  endtask

  task automatic test_random();
    logic [9:0] sw = '0;
    int hold = 0;
    int r;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 4)      sw = 10'h000;
        else if (r < 8) sw = 10'(1) << $urandom_range(0, 9);
        else            sw = 10'($urandom_range(1, 1023));
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      step($urandom_range(0, 99) == 0, sw);
      n_checks++; if (obs !== m_vec()) $display("FAIL random_model cyc %0d got %h want %h", i, obs, m_vec()); else n_pass++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    sw_raw = '0;
    m_s1 = '0; m_s2 = '0; m_armed = 1; m_run_len = 0; m_zero_run = 0; m_run_val = '0; m_tk = '0; m_me = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_key_roll();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tenkey_debounce.md
TENKEY_DEBOUNCE -- requirements
Module: tenkey_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive identical synchronized samples required to accept a press or release; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port sw_raw, input, 10 bits: raw asynchronous keypad switches, where bit i set means digit i is pressed.
REQ-005 The block SHALL have port tenkey, output, 10 bits, registered: a one-hot accepted key, high for exactly one cycle per accepted press and otherwise 0.
REQ-006 The block SHALL have port key_valid, output, 1 bit, registered: equal to the OR of all tenkey bits.
REQ-007 The block SHALL have port key_code, output, 4 bits, registered: the binary digit 0..9 of the accepted key while key_valid is high, and 4'hF otherwise.
REQ-008 The block SHALL have port multi_err, output, 1 bit, registered: a one-cycle pulse when two or more keys are detected outside RELEASE.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 sw_raw SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronizer output "sync".
REQ-011 The FSM SHALL have exactly the states IDLE, DEBOUNCE, RELEASE, plus an 8-bit counter cnt and a 10-bit candidate register cand.
REQ-012 In IDLE, when sync==0 the FSM SHALL stay in IDLE; when sync is one-hot it SHALL load cand=sync, set cnt=1 and go to DEBOUNCE; when sync is multi-hot it SHALL pulse multi_err and go to RELEASE with cnt=0.
REQ-013 In DEBOUNCE, when sync==cand and cnt<DEBOUNCE_CYCLES-1, the FSM SHALL increment cnt.
REQ-014 In DEBOUNCE, when sync==cand and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL register tenkey=cand, key_valid=1 and key_code=encode(cand) for the following cycle only, then go to RELEASE with cnt=0.
REQ-015 In DEBOUNCE, when sync!=cand: if sync==0 the FSM SHALL return to IDLE; if sync is a different one-hot value it SHALL reload cand=sync with cnt=1; if sync is multi-hot it SHALL pulse multi_err and go to RELEASE with cnt=0.
REQ-016 In RELEASE, each sync==0 sample SHALL increment cnt and any nonzero sample SHALL clear cnt; when cnt reaches DEBOUNCE_CYCLES with sync==0 the FSM SHALL go to IDLE; RELEASE SHALL NOT generate tenkey or multi_err.
REQ-017 Acceptance latency: counting edge 0 as the first edge that samples a stable one-hot sw_raw, tenkey SHALL be high during the cycle after edge DEBOUNCE_CYCLES+1.
REQ-018 A held key SHALL produce exactly one tenkey pulse; no auto-repeat is permitted.
REQ-019 A new press SHALL be accepted only after a complete release: the FSM SHALL pass through RELEASE back to IDLE first.
REQ-020 tenkey SHALL always be 0 or one-hot; key_valid and key_code SHALL change in the same cycle as tenkey.
REQ-021 multi_err and tenkey SHALL never be high in the same cycle.
REQ-022 busy SHALL be combinational from the state register.

Reset
REQ-023 When rst is high at a clock edge, the block SHALL set: state=IDLE, cnt=0, cand=0, both synchronizer flops=0, tenkey=0, key_valid=0, key_code=4'hF, multi_err=0.
REQ-024 rst SHALL take priority over all other inputs; a reset mid-DEBOUNCE or mid-RELEASE SHALL discard the pending press and emit no pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Reset: assert rst for 2 cycles with sw_raw=10'h3FF -> tenkey=0, key_valid=0, key_code=F, multi_err=0, busy=0.
REQ-026 Clean press: sw_raw=10'h080 held for 12 cycles, then 0 -> tenkey=10'h080, key_valid=1 and key_code=7 for exactly one cycle after edge 5; no further pulse; busy=0 about 6 cycles after release.
REQ-027 Bounce: 10'h080 for 2 cycles, 0 for 1 cycle, then 10'h080 held -> a single pulse, timed from the start of the final stable run.
REQ-028 Multi-key: sw_raw=10'h081 -> one multi_err pulse, no tenkey; then 10'h001 without any zero gap -> no pulse until sw_raw=0 for 4 synchronized cycles, then 10'h001 is accepted normally.
REQ-029 Key roll: hold 10'h080 through acceptance, then switch directly to 10'h100 -> no second pulse until release completes.
REQ-030 Reset mid-DEBOUNCE: rst pulsed at cnt=2 while 10'h200 is held -> no pulse; after rst drops, 10'h200 is accepted with full latency, key_code=9.
